det_stream_sched: RTL and testbench
===================================

Name: det_stream_sched

Overview:
- Round-robin scheduler that shares one 1011 serial sequence detector among N requesters.
- Each requester hands over a W-bit word with a valid/ready handshake. The block clears the detector, shifts the word in MSB-first, counts detector hits, and returns the hit count tagged with the requester id.
- Sits between the requester-side logic and the detector. The block exclusively owns the detector's clk-domain reset and serial input.

Parameters:
- N, 4: number of requesters (2..8).
- W, 8: word width in bits shifted per transaction (4..32).
- DET_LAT, 1: cycles from a bit driven on det_in to the detector's corresponding det_out sample (1..3).
- IDW, derived $clog2(N): width of the requester id.
- CW, derived $clog2(W+1): width of the hit count.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- req_valid  in  N  per-requester word valid.
- req_data  in  N*W  packed words; requester i occupies bits [i*W +: W].
- req_ready  out  N  one-hot accept pulse; a word is accepted when req_valid[i] && req_ready[i].
- det_rstn  out  1  detector synchronous active-low reset (registered).
- det_in  out  1  detector serial input (registered).
- det_out  in  1  detector match flag.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester id of the completed word.
- rsp_count  out  CW  number of det_out hits for the word.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. The clock port is clk and the reset port is rstn.
- Reset values:
  - req_ready=0, det_rstn=0, det_in=0, rsp_valid=0, rsp_id=0, rsp_count=0.
  - state=IDLE, rr pointer=N-1, so requester 0 has first priority.
- FSM IDLE -> CLR -> SHIFT -> DRAIN -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from (ptr+1) mod N upward with wrap.
  - The grant drives req_ready[g]=1 for exactly that cycle, captures req_data[g] into the shift register, sets ptr=g, and clears the counter.
  - The next state is CLR.
  - req_ready is never asserted outside IDLE and is never asserted when the corresponding req_valid is 0.
- CLR: det_rstn=0 and det_in=0 for exactly 1 cycle. This guarantees no pattern spans two words.
- SHIFT:
  - W cycles with det_rstn=1; det_in = shreg MSB, then shift left by 1.
  - The cycle index k counts from 0 at SHIFT entry.
- DRAIN: DET_LAT cycles with det_in=0 and det_rstn=1.
- Counting:
  - Sample det_out at k in [DET_LAT, W+DET_LAT-1], counting continuously across SHIFT and DRAIN.
  - The count saturates at 2^CW-1; this is unreachable for a 1011 detector and is kept only as a guard.
- RESP:
  - rsp_valid=1 with rsp_id and rsp_count stable until the cycle where rsp_valid && rsp_ready, then go to IDLE.
  - det_rstn stays 1 in RESP and IDLE; the detector idles on det_in=0.
- Latency:
  - Accept at cycle T. CLR at T+1. SHIFT at T+2..T+W+1. DRAIN follows for DET_LAT cycles.
  - rsp_valid first asserts at T+W+DET_LAT+2.
  - With rsp_ready held 1, the next accept can occur at the earliest 1 cycle after the response handshake.
- Boundaries:
  - A requester dropping req_valid while another transaction is in flight is ignored; no grant is made.
  - A requester re-asserting immediately after its own response is served only after all other pending requesters, per round-robin.
  - Simultaneous rsp handshake and new req_valid: the grant happens in the following IDLE cycle and is not combined.
  - rstn low in any state returns everything to reset values within 1 clock. Any in-flight word is dropped with no response, det_rstn=0, and ptr=N-1.

Test Plan:
- Single word: req0 sends 8'b1011_0000, rsp_ready=1 -> req_ready[0] pulses once; det_in bits 1,0,1,1,0,0,0,0 appear at T+2..T+9; rsp_valid at T+11 with id=0, count=1.
- Overlap: req2 sends 8'b1011_0110 -> id=2, count=2 (matches at bits 0-3 and 3-6). Then 8'b1011_1011 -> count=2.
- Word isolation: req0 sends 8'b0000_0101, then req1 sends 8'b1000_0000 -> both counts=0. det_rstn is observed low for exactly one cycle before each word.
- Round-robin: all four req_valid held high with distinct words -> grant order 0,1,2,3,0. req_ready stays one-hot and pulses exactly once per accept.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_count are stable, and no req_ready is asserted. rsp_ready=1 -> handshake, then the next grant.
- Reset mid-SHIFT: rstn=0 at SHIFT k=3 for 2 cycles -> next cycle all outputs are at reset values and no response is emitted. After release, req1 and req3 pending -> req1 is granted first.

Source files
------------

// File: rtl/det_stream_sched.sv
// ============================================================================
//  Module      : det_stream_sched
//  Description : Round-robin scheduler sharing one serial 1011 detector among
//                N word requesters; returns per-word hit counts tagged by id.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module det_stream_sched #(
    parameter  int N       = 4,
    parameter  int W       = 8,
    parameter  int DET_LAT = 1,
    localparam int IDW     = $clog2(N),
    localparam int CW      = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             det_rstn,
    output logic             det_in,
    input  logic             det_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [CW-1:0]    rsp_count
);

    localparam int KW = $clog2(W + DET_LAT + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]     state_q,    state_d;
    logic [IDW-1:0] ptr_q,      ptr_d;
    logic [IDW-1:0] id_q,       id_d;
    logic [W-1:0]   shreg_q,    shreg_d;
    logic [KW-1:0]  k_q,        k_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic           det_rstn_q, det_rstn_d;
    logic           det_in_q,   det_in_d;

    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    logic [W-1:0]   grant_word;
    logic           accept;
    logic           sample_hit;

    // Search downward so the candidate closest to ptr+1 is written last and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = N; i >= 1; i--) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_word = req_data[i*W +: W];
            end
        end
    end

    assign accept = rstn && (state_q == ST_IDLE) && grant_valid;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Hits are valid once the first shifted bit has propagated through the detector.
    assign sample_hit = (k_q >= KW'(DET_LAT)) && det_out && (cnt_q != '1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        shreg_d    = shreg_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        det_rstn_d = det_rstn_q;
        det_in_d   = det_in_q;

        case (state_q)
            ST_IDLE: begin
                det_rstn_d = 1'b1;
                det_in_d   = 1'b0;
                if (accept) begin
                    state_d    = ST_CLR;
                    ptr_d      = grant_idx;
                    id_d       = grant_idx;
                    shreg_d    = grant_word;
                    cnt_d      = '0;
                    det_rstn_d = 1'b0;
                end
            end
            ST_CLR: begin
                state_d    = ST_SHIFT;
                det_rstn_d = 1'b1;
                det_in_d   = shreg_q[W-1];
                shreg_d    = shreg_q << 1;
                k_d        = '0;
            end
            ST_SHIFT: begin
                k_d = k_q + KW'(1);
                if (sample_hit) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (k_q == KW'(W - 1)) begin
                    state_d  = ST_DRAIN;
                    det_in_d = 1'b0;
                end else begin
                    det_in_d = shreg_q[W-1];
                    shreg_d  = shreg_q << 1;
                end
            end
            ST_DRAIN: begin
                k_d      = k_q + KW'(1);
                det_in_d = 1'b0;
                if (sample_hit) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (k_q == KW'(W + DET_LAT - 1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDW'(N - 1);
            id_q       <= '0;
            shreg_q    <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            det_rstn_q <= 1'b0;
            det_in_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            shreg_q    <= shreg_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            det_rstn_q <= det_rstn_d;
            det_in_q   <= det_in_d;
        end
    end

    assign det_rstn  = det_rstn_q;
    assign det_in    = det_in_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_det_stream_sched.sv
// ============================================================================
//  Module      : tb_det_stream_sched
//  Description : Directed self-checking bench for det_stream_sched with a
//                behavioural 1011 detector (latency 1) on the serial side.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_det_stream_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int DL  = 1;
    localparam int IDW = 2;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           det_rstn;
    logic           det_in;
    logic           det_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [CW-1:0]  rsp_count;

    int n_checks = 0;
    int n_errors = 0;
    int w;

    det_stream_sched #(.N(N), .W(W), .DET_LAT(DL)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_rstn  (det_rstn),
        .det_in    (det_in),
        .det_out   (det_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count)
    );

    always #5 clk = ~clk;

    // Overlapping 1011 detector, one cycle from det_in to det_out.
    logic [2:0] hist;
    always @(posedge clk) begin
        if (!det_rstn) begin
            hist    <= 3'b000;
            det_out <= 1'b0;
        end else begin
            hist    <= {hist[1:0], det_in};
            det_out <= ({hist, det_in} == 4'b1011);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge in IDLE; leaves just after the negedge of the
    // IDLE cycle that follows the response handshake.
    task automatic run_word(input int id, input logic [W-1:0] word, input int exp_cnt,
                            input int hold, input bit chk_pre, input bit drop_all,
                            output int waited);
        logic [W-1:0] got;
        bit rst_bad, drain_bad, quiet_bad, bp_bad;
        got = '0; rst_bad = 0; drain_bad = 0; quiet_bad = 0; bp_bad = 0;
        waited = 0;
        req_data[id*W +: W] = word;
        req_valid[id]       = 1'b1;
        rsp_ready           = (hold == 0);
        #1;
        while (req_ready == '0 && waited < 40) begin
            @(negedge clk); #1;
            waited++;
        end
        chk($sformatf("grant_id%0d", id), 32'(req_ready), 32'(1) << id);
        if (req_ready == '0) return;
        if (chk_pre) chk("det_rstn_pre", 32'(det_rstn), 32'(1));
        @(posedge clk); #1;
        if (drop_all) req_valid = '0;
        for (int j = 1; j <= W + DL + 1; j++) begin
            @(negedge clk); #1;
            if (j == 1) begin
                chk("clr_det_rstn", 32'(det_rstn), 32'(0));
                chk("clr_det_in", 32'(det_in), 32'(0));
            end else if (j <= W + 1) begin
                got[W-1-(j-2)] = det_in;
                if (!det_rstn) rst_bad = 1;
            end else begin
                if (det_in || !det_rstn) drain_bad = 1;
            end
            if (rsp_valid || req_ready != '0) quiet_bad = 1;
        end
        chk("shift_bits", 32'(got), 32'(word));
        chk("shift_det_rstn", 32'(rst_bad), 32'(0));
        chk("drain_idle", 32'(drain_bad), 32'(0));
        chk("busy_quiet", 32'(quiet_bad), 32'(0));
        @(negedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(1));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_count", 32'(rsp_count), 32'(exp_cnt));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_id != IDW'(id) || rsp_count != CW'(exp_cnt) || req_ready != '0)
                bp_bad = 1;
        end
        if (hold > 0) begin
            chk("bp_stable", 32'(bp_bad), 32'(0));
            rsp_ready = 1'b1;
        end
        @(negedge clk); #1;
        chk("rsp_done", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_det_rstn", 32'(det_rstn), 32'(0));
        chk("rst_det_in", 32'(det_in), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_count", 32'(rsp_count), 32'(0));
        rstn = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;

        // Single word, then overlapping patterns
        run_word(0, 8'hB0, 1, 0, 1, 1, w);
        run_word(2, 8'hB6, 2, 0, 1, 1, w);
        run_word(2, 8'hBB, 2, 0, 1, 1, w);

        // Word isolation: tail 0101 followed by 1 must not match across words
        run_word(0, 8'h05, 0, 0, 1, 1, w);
        run_word(1, 8'h80, 0, 0, 1, 1, w);

        // Backpressure with requester 0 pending behind requester 3
        req_data[0*W +: W] = 8'h0B;
        req_valid[0]       = 1'b1;
        run_word(3, 8'hBB, 2, 20, 1, 0, w);
        run_word(0, 8'h0B, 1, 0, 1, 1, w);
        chk("bp_next_grant_wait", 32'(w), 32'(0));
        run_word(3, 8'h00, 0, 0, 1, 1, w);

        // Round-robin with everyone held valid
        req_data  = {8'h00, 8'hB6, 8'h0B, 8'hB0};
        req_valid = 4'hF;
        run_word(0, 8'hB0, 1, 0, 1, 0, w);
        run_word(1, 8'h0B, 1, 0, 1, 0, w);
        run_word(2, 8'hB6, 2, 0, 1, 0, w);
        run_word(3, 8'h00, 0, 0, 1, 0, w);
        run_word(0, 8'hB0, 1, 0, 1, 1, w);

        // Reset during SHIFT k=3
        req_data[2*W +: W] = 8'hB0;
        req_valid[2]       = 1'b1;
        #1;
        w = 0;
        while (req_ready == '0 && w < 40) begin
            @(negedge clk); #1;
            w++;
        end
        chk("mid_grant", 32'(req_ready), 32'(4'b0100));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(negedge clk);
        #1;
        rstn = 1'b0;
        req_data[1*W +: W] = 8'hB6;
        req_data[3*W +: W] = 8'h0B;
        req_valid = 4'b1010;
        @(negedge clk); #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
        chk("mid_rst_det_rstn", 32'(det_rstn), 32'(0));
        chk("mid_rst_det_in", 32'(det_in), 32'(0));
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("mid_rst_rsp_count", 32'(rsp_count), 32'(0));
        @(negedge clk); #1;
        chk("mid_rst_rsp_valid2", 32'(rsp_valid), 32'(0));
        rstn = 1'b1;
        run_word(1, 8'hB6, 2, 0, 0, 0, w);
        chk("post_rst_grant_wait", 32'(w), 32'(0));
        run_word(3, 8'h0B, 1, 0, 1, 1, w);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
